seven_seg_scan: RTL and testbench

//  Time-multiplexed driver for the board's 4-digit 7-segment display (seven_seg_sel[4:1], a..g, dp, minus).

---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/seven_seg_hex_decode.sv | 36 +++
 rtl/seven_seg_scan.sv | 162 ++++++++++++++++
 tb/tb_seven_seg_scan.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_pkg : shared types and segment patterns for seven_seg_scan, rev 1.0
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  // Patterns are {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_hex_decode : hex nibble to active-high 7-segment pattern, rev 1.0
// ---------------------------------------------------------------------------
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seven_seg_scan : 4-digit multiplexed 7-segment driver with frame-aligned updates, rev 1.0
// ---------------------------------------------------------------------------
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DRIVE_CYCLES = 49000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clkin_50,
  input  logic        cpu_reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_value,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_blank,
  input  logic        upd_minus,
  output logic        frame_tick,
  output logic [4:1]  seven_seg_sel,
  output logic [6:0]  seven_seg_seg,
  output logic        seven_seg_dp,
  output logic        seven_seg_minus
);

  localparam int MAX_CYCLES = max_int(DRIVE_CYCLES, BLANK_CYCLES);
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] DRIVE_LAST = TW'(DRIVE_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [15:0]   pending_value;
  logic [3:0]    pending_dp;
  logic [3:0]    pending_blank;
  logic          pending_minus;
  logic          pending_full;

  logic [15:0]   active_value;
  logic [3:0]    active_dp;
  logic [3:0]    active_blank;
  logic          active_minus;

  state_t        state, state_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          wrap;

  logic [3:0]    nibble_sel;
  logic [6:0]    pattern;
  logic          lit;
  logic [3:0]    sel_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign upd_ready = ~pending_full & ~cpu_reset;

  // frame_tick is high exactly in the first BLANK cycle of a frame, so it
  // doubles as the commit strobe: the pending slot can only move then.
  always_ff @(posedge clkin_50 or posedge cpu_reset) begin
    if (cpu_reset) begin
      pending_value <= '0;
      pending_dp    <= '0;
      pending_blank <= '0;
      pending_minus <= 1'b0;
      pending_full  <= 1'b0;
      active_value  <= '0;
      active_dp     <= '0;
      active_blank  <= 4'hF;
      active_minus  <= 1'b0;
    end else if (frame_tick && pending_full) begin
      active_value  <= pending_value;
      active_dp     <= pending_dp;
      active_blank  <= pending_blank;
      active_minus  <= pending_minus;
      pending_full  <= 1'b0;
    end else if (upd_valid && upd_ready) begin
      pending_value <= upd_value;
      pending_dp    <= upd_dp;
      pending_blank <= upd_blank;
      pending_minus <= upd_minus;
      pending_full  <= 1'b1;
    end
  end

  always_ff @(posedge clkin_50 or posedge cpu_reset) begin
    if (cpu_reset) begin
      state      <= S_BLANK;
      digit      <= 2'd0;
      timer      <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      digit      <= digit_nxt;
      timer      <= timer_nxt;
      frame_tick <= wrap;
    end
  end

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    timer_nxt = timer + 1'b1;
    wrap      = 1'b0;
    case (state)
      S_BLANK: begin
        if (timer == BLANK_LAST) begin
          state_nxt = S_DRIVE;
          timer_nxt = '0;
        end
      end
      S_DRIVE: begin
        if (timer == DRIVE_LAST) begin
          state_nxt = S_BLANK;
          timer_nxt = '0;
          digit_nxt = digit + 2'd1;
          wrap      = (digit == 2'd3);
        end
      end
      default: begin
        state_nxt = S_BLANK;
        timer_nxt = '0;
      end
    endcase
  end

  assign nibble_sel = active_value[{digit, 2'b00} +: 4];

  seven_seg_hex_decode u_decode (
    .nibble  (nibble_sel),
    .pattern (pattern)
  );

  // A blanked digit keeps its enable, segments and dp all dark
  always_comb begin
    lit     = (state == S_DRIVE) && !active_blank[digit];
    sel_nxt = 4'b0000;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b0;
    if (lit) begin
      sel_nxt = 4'b0001 << digit;
      seg_nxt = pattern;
      dp_nxt  = active_dp[digit];
    end
  end

  always_ff @(posedge clkin_50 or posedge cpu_reset) begin
    if (cpu_reset) begin
      seven_seg_sel   <= {4{POL}};
      seven_seg_seg   <= {7{POL}};
      seven_seg_dp    <= POL;
      seven_seg_minus <= POL;
    end else begin
      seven_seg_sel   <= sel_nxt ^ {4{POL}};
      seven_seg_seg   <= seg_nxt ^ {7{POL}};
      seven_seg_dp    <= dp_nxt ^ POL;
      seven_seg_minus <= active_minus ^ POL;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seven_seg_scan : randomized bench for seven_seg_scan (low- and high-true builds), rev 1.0
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int DRIVE = 8;
  localparam int BLANK = 2;
  localparam int SLOT  = DRIVE + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_value = 16'h0;
  logic [3:0]  upd_dp = 4'h0;
  logic [3:0]  upd_blank = 4'h0;
  logic        upd_minus = 1'b0;

  wire         ready_l, ft_l, dp_l, minus_l;
  wire  [3:0]  sel_l;
  wire  [6:0]  seg_l;
  wire         ready_h, ft_h, dp_h, minus_h;
  wire  [3:0]  sel_h;
  wire  [6:0]  seg_h;

  wire [14:0] obs_l = {sel_l, seg_l, dp_l, minus_l, ready_l, ft_l};
  wire [14:0] obs_h = {sel_h, seg_h, dp_h, minus_h, ready_h, ft_h};

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: cycle index since reset release and the
  // pending/active registers as the behaviour describes them.
  int          n;
  logic        full;
  logic [15:0] pend_val, act_val;
  logic [3:0]  pend_dp, pend_blk, act_dp, act_blk;
  logic        pend_mn, act_mn;
  logic [3:0]  e_sel;
  logic [6:0]  e_seg;
  logic        e_dp, e_mn, e_ready, e_ft;

  seven_seg_scan #(.DRIVE_CYCLES(DRIVE), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1)) dut_l (
    .clkin_50(clk), .cpu_reset(rst), .upd_valid(upd_valid), .upd_ready(ready_l),
    .upd_value(upd_value), .upd_dp(upd_dp), .upd_blank(upd_blank), .upd_minus(upd_minus),
    .frame_tick(ft_l), .seven_seg_sel(sel_l), .seven_seg_seg(seg_l),
    .seven_seg_dp(dp_l), .seven_seg_minus(minus_l)
  );

  seven_seg_scan #(.DRIVE_CYCLES(DRIVE), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(0)) dut_h (
    .clkin_50(clk), .cpu_reset(rst), .upd_valid(upd_valid), .upd_ready(ready_h),
    .upd_value(upd_value), .upd_dp(upd_dp), .upd_blank(upd_blank), .upd_minus(upd_minus),
    .frame_tick(ft_h), .seven_seg_sel(sel_h), .seven_seg_seg(seg_h),
    .seven_seg_dp(dp_h), .seven_seg_minus(minus_h)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[h];
  endfunction

  function automatic logic [14:0] exp_h();
    return {e_sel, e_seg, e_dp, e_mn, e_ready, e_ft};
  endfunction

  function automatic logic [14:0] exp_l();
    return {~e_sel, ~e_seg, ~e_dp, ~e_mn, e_ready, e_ft};
  endfunction

  task automatic model_reset();
    full = 1'b0; pend_val = '0; pend_dp = '0; pend_blk = '0; pend_mn = 1'b0;
    act_val = '0; act_dp = '0; act_blk = 4'hF; act_mn = 1'b0;
    n = 0; e_sel = '0; e_seg = '0; e_dp = 1'b0; e_mn = 1'b0; e_ready = 1'b0; e_ft = 1'b0;
  endtask

  task automatic assert_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset(input int hold);
    upd_valid = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    e_ready = 1'b1;
    #1;
  endtask

  // Drive inputs for cycle n, evolve the model across the clock edge, land on cycle n+1.
  task automatic advance(input logic v, input logic [15:0] val, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic mn);
    int p, d, w;
    logic ft;
    upd_valid = v; upd_value = val; upd_dp = dpv; upd_blank = blk; upd_minus = mn;
    ft = (n > 0) && (n % FRAME == 0);
    p = n % FRAME; d = p / SLOT; w = p % SLOT;
    if (w < BLANK || act_blk[d]) begin
      e_sel = 4'h0; e_seg = 7'h00; e_dp = 1'b0;
    end else begin
      e_sel = 4'(1 << d); e_seg = hex7(act_val[d*4 +: 4]); e_dp = act_dp[d];
    end
    e_mn = act_mn;
    if (ft && full) begin
      act_val = pend_val; act_dp = pend_dp; act_blk = pend_blk; act_mn = pend_mn; full = 1'b0;
    end else if (v && !full) begin
      pend_val = val; pend_dp = dpv; pend_blk = blk; pend_mn = mn; full = 1'b1;
    end
    n++;
    e_ready = !full;
    e_ft = (n % FRAME == 0);
    @(negedge clk);
  endtask

  task automatic idle();
    advance(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic sync_to_frame();
    int guard = 0;
    while (!e_ft && guard < 2 * FRAME) begin
      idle();
      guard++;
    end
    compared++;
    if (ft_l !== 1'b1) begin
      mismatched++;
      $display("FAIL sync_frame_tick n=%0d got %b want 1", n, ft_l);
    end
  endtask

  task automatic test_reset();
    int ticks = 0;
    assert_reset();
    compared++;
    if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
      mismatched++;
      $display("FAIL reset_async got %h/%h want %h/%h", obs_l, obs_h, exp_l(), exp_h());
    end
    release_reset(3);
    compared++;
    if (ready_l !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_release got %b want 1", ready_l);
    end
    for (int i = 0; i <= 2 * FRAME; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()} || sel_l !== 4'hF) begin
        mismatched++;
        $display("FAIL reset_frames n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      if (ft_l === 1'b1) ticks++;
      idle();
    end
    compared++;
    if (ticks !== 2) begin
      mismatched++;
      $display("FAIL reset_tick_count got %0d want 2", ticks);
    end
  endtask

  task automatic test_value();
    int lit2 = 0;
    sync_to_frame();
    advance(1'b1, 16'h12AF, 4'b0100, 4'h0, 1'b0);
    for (int i = 1; i < 86; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
        mismatched++;
        $display("FAIL value_12AF n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      if (sel_h === 4'b0100 && seg_h === 7'h5B && dp_h === 1'b1) lit2++;
      idle();
    end
    compared++;
    if (lit2 !== DRIVE) begin
      mismatched++;
      $display("FAIL value_digit2_cycles got %0d want %0d", lit2, DRIVE);
    end
  endtask

  task automatic test_hold_valid();
    int cnt = 0;
    sync_to_frame();
    for (int i = 0; i <= 4 * FRAME; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
        mismatched++;
        $display("FAIL hold_valid n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      if (i > 0 && ft_l === 1'b1) begin
        compared++;
        if (cnt !== 1) begin
          mismatched++;
          $display("FAIL transfers_per_frame n=%0d got %0d want 1", n, cnt);
        end
        cnt = 0;
      end
      if (ready_l === 1'b1) cnt++;
      advance(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_blank_minus();
    sync_to_frame();
    advance(1'b1, 16'($urandom), 4'($urandom), 4'b1000, 1'b1);
    for (int i = 1; i < 130; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
        mismatched++;
        $display("FAIL blank_minus n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      if (i >= 45) begin
        compared++;
        if (sel_l[3] !== 1'b1 || minus_l !== 1'b0 || minus_h !== 1'b1) begin
          mismatched++;
          $display("FAIL digit3_dark_minus_lit n=%0d got sel=%b minus=%b/%b want sel[3]=1 minus=0/1",
                   n, sel_l, minus_l, minus_h);
        end
      end
      idle();
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    sync_to_frame();
    advance(1'b1, 16'($urandom), 4'($urandom), 4'h0, 1'($urandom));
    while (n % FRAME != 2 * SLOT + BLANK + 2 && guard < FRAME) begin
      idle();
      guard++;
    end
    compared++;
    if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
      mismatched++;
      $display("FAIL before_mid_reset n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
    end
    assert_reset();
    compared++;
    if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
      mismatched++;
      $display("FAIL mid_reset_async got %h/%h want %h/%h", obs_l, obs_h, exp_l(), exp_h());
    end
    release_reset(2);
    for (int i = 0; i <= 2 * FRAME; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()} || sel_l !== 4'hF) begin
        mismatched++;
        $display("FAIL after_mid_reset n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      idle();
    end
  endtask

  task automatic test_active_high();
    sync_to_frame();
    advance(1'b1, 16'h8888, 4'h0, 4'h0, 1'b0);
    for (int i = 1; i < 86; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
        mismatched++;
        $display("FAIL value_8888 n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      if (i >= 41) begin
        compared++;
        if (sel_h !== 4'h0 && (seg_h !== 7'h7F || !$onehot(sel_h))) begin
          mismatched++;
          $display("FAIL high_true_lit n=%0d got sel=%b seg=%h want onehot sel seg=7f", n, sel_h, seg_h);
        end else if (sel_h === 4'h0 && {seg_h, dp_h, minus_h} !== 9'h0) begin
          mismatched++;
          $display("FAIL high_true_dark n=%0d got seg=%h dp=%b minus=%b want 0", n, seg_h, dp_h, minus_h);
        end
      end
      idle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      compared++;
      if ({obs_l, obs_h} !== {exp_l(), exp_h()}) begin
        mismatched++;
        $display("FAIL random n=%0d got %h/%h want %h/%h", n, obs_l, obs_h, exp_l(), exp_h());
      end
      advance(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_value();
    test_hold_valid();
    test_blank_minus();
    test_reset_mid();
    test_active_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
